// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and defaults for the pipeline stall/flush/redirect scheduler
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } pipe_ctrl_state_t;

    typedef enum logic [1:0] {
        REDIR_SEQ    = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_EXC    = 2'd2,
        REDIR_EPC    = 2'd3
    } redirect_src_t;

    localparam int EXC_DRAIN_DEFAULT   = 2;
    localparam int MEM_TIMEOUT_DEFAULT = 16;

    typedef struct packed {
        logic          stall_if;
        logic          stall_id;
        logic          stall_ex;
        logic          stall_mem;
        logic          bubble_ex;
        logic          flush_id;
        logic          flush_ex;
        redirect_src_t redirect;
        logic          mem_timeout;
    } ctrl_out_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between the EX load and the ID readers
module load_use_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_writeenable,
    input  logic       ex_is_load,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_rd);
    assign rt_match = id_uses_rt && (id_rt == ex_rd);

    // $zero is never a real dependency, so a load targeting it cannot stall
    assign hazard = ex_is_load && ex_writeenable && (ex_rd != 5'd0) && id_valid
                    && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/redirect scheduler for the 5-stage pipeline; PIPELINE_CTRL_PERF_EN adds perf counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEFAULT,
    parameter int DRAIN_CYCLES = EXC_DRAIN_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_writeenable,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic        ex_exception,
    input  logic        ex_eret,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [1:0]  redirect_sel,
    output logic        mem_timeout,
    output logic [31:0] load_stall_cnt,
    output logic [31:0] mem_wait_cnt
);

    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

    pipe_ctrl_state_t state, state_nx;
    logic [7:0]       wait_cnt, wait_nx;
    logic [2:0]       drain_cnt, drain_nx;
    logic             rst_q;
    logic             blank;
    logic             hazard;
    ctrl_out_t        cn;
    ctrl_out_t        co;

    load_use_detect u_load_use_detect (
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .ex_rd          (ex_rd),
        .ex_writeenable (ex_writeenable),
        .ex_is_load     (ex_is_load),
        .hazard         (hazard)
    );

    // Outputs are silenced while reset is high and for the one cycle after it
    assign blank = reset || rst_q;

    always_comb begin
        cn        = '0;
        state_nx  = state;
        wait_nx   = wait_cnt;
        drain_nx  = drain_cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    cn.stall_if  = 1'b1;
                    cn.stall_id  = 1'b1;
                    cn.stall_ex  = 1'b1;
                    cn.stall_mem = 1'b1;
                    state_nx     = MEM_WAIT;
                    wait_nx      = 8'd1;
                end else if (ex_exception) begin
                    cn.redirect = REDIR_EXC;
                    cn.flush_id = 1'b1;
                    cn.flush_ex = 1'b1;
                    state_nx    = DRAIN;
                    drain_nx    = DRAIN_LOAD;
                end else if (ex_eret) begin
                    cn.redirect = REDIR_EPC;
                    cn.flush_id = 1'b1;
                    cn.flush_ex = 1'b1;
                end else if (ex_branch_taken) begin
                    cn.redirect = REDIR_BRANCH;
                    cn.flush_id = 1'b1;
                end else if (hazard) begin
                    cn.stall_if  = 1'b1;
                    cn.stall_id  = 1'b1;
                    cn.bubble_ex = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nx = RUN;
                    wait_nx  = 8'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Timeout becomes an exception; the PC must load the vector, so no stalls
                    cn.mem_timeout = 1'b1;
                    cn.redirect    = REDIR_EXC;
                    cn.flush_id    = 1'b1;
                    cn.flush_ex    = 1'b1;
                    state_nx       = DRAIN;
                    wait_nx        = 8'd0;
                    drain_nx       = DRAIN_LOAD;
                end else begin
                    cn.stall_if  = 1'b1;
                    cn.stall_id  = 1'b1;
                    cn.stall_ex  = 1'b1;
                    cn.stall_mem = 1'b1;
                    wait_nx      = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (ex_exception) begin
                    cn.redirect = REDIR_EXC;
                    cn.flush_id = 1'b1;
                    cn.flush_ex = 1'b1;
                    drain_nx    = DRAIN_LOAD;
                end else begin
                    cn.stall_if = 1'b1;
                    cn.flush_id = 1'b1;
                    drain_nx    = drain_cnt - 3'd1;
                    if (drain_cnt <= 3'd1) begin
                        state_nx = RUN;
                        drain_nx = 3'd0;
                    end
                end
            end
            default: begin
                state_nx = RUN;
                wait_nx  = 8'd0;
                drain_nx = 3'd0;
            end
        endcase
    end

    assign co = blank ? '0 : cn;

    always_ff @(posedge clock) begin
        rst_q <= reset;
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            drain_cnt <= 3'd0;
        end else if (!rst_q) begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            drain_cnt <= drain_nx;
        end
    end

    assign stall_if     = co.stall_if;
    assign stall_id     = co.stall_id;
    assign stall_ex     = co.stall_ex;
    assign stall_mem    = co.stall_mem;
    assign bubble_ex    = co.bubble_ex;
    assign flush_id     = co.flush_id;
    assign flush_ex     = co.flush_ex;
    assign redirect_sel = co.redirect;
    assign mem_timeout  = co.mem_timeout;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] load_stall_q;
    logic [31:0] mem_wait_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            load_stall_q <= 32'd0;
            mem_wait_q   <= 32'd0;
        end else begin
            if (co.bubble_ex) begin
                load_stall_q <= load_stall_q + 32'd1;
            end
            if (!blank && state == MEM_WAIT) begin
                mem_wait_q <= mem_wait_q + 32'd1;
            end
        end
    end

    assign load_stall_cnt = load_stall_q;
    assign mem_wait_cnt   = mem_wait_q;
`else
    assign load_stall_cnt = 32'd0;
    assign mem_wait_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized self-checking bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT  = 16;
    localparam int DRAIN_CYCLES = 2;

    typedef struct packed {
        logic       reset;
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic [4:0] ex_rd;
        logic       ex_writeenable;
        logic       ex_is_load;
        logic       ex_branch_taken;
        logic       ex_exception;
        logic       ex_eret;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    logic        clock = 1'b0;
    stim_t       s;
    stim_t       d;
    logic        stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_id, flush_ex;
    logic [1:0]  redirect_sel;
    logic        mem_timeout;
    logic [31:0] load_stall_cnt, mem_wait_cnt;

    always #5 clock = ~clock;

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clock           (clock),
        .reset           (d.reset),
        .id_valid        (d.id_valid),
        .id_rs           (d.id_rs),
        .id_rt           (d.id_rt),
        .id_uses_rs      (d.id_uses_rs),
        .id_uses_rt      (d.id_uses_rt),
        .ex_rd           (d.ex_rd),
        .ex_writeenable  (d.ex_writeenable),
        .ex_is_load      (d.ex_is_load),
        .ex_branch_taken (d.ex_branch_taken),
        .ex_exception    (d.ex_exception),
        .ex_eret         (d.ex_eret),
        .mem_req         (d.mem_req),
        .mem_ready       (d.mem_ready),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .stall_ex        (stall_ex),
        .stall_mem       (stall_mem),
        .bubble_ex       (bubble_ex),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .redirect_sel    (redirect_sel),
        .mem_timeout     (mem_timeout),
        .load_stall_cnt  (load_stall_cnt),
        .mem_wait_cnt    (mem_wait_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: "waiting" tracks an outstanding stalled access and how many
    // cycles it has already cost; "drain_left" is how many IF-hold cycles remain.
    bit          m_waiting    = 1'b0;
    int          m_waited     = 0;
    int          m_drain_left = 0;
    bit          m_blank      = 1'b0;
    int unsigned m_lu         = 0;
    int unsigned m_mw         = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
                    flush_id, flush_ex, redirect_sel, mem_timeout});
    endfunction

    task automatic run_cycle();
        bit e_sif, e_sid, e_sex, e_smem, e_bub, e_fid, e_fex, e_to, hz;
        int e_red;
        @(posedge clock);
        #1;
        d = s;
        @(negedge clock);
        {e_sif, e_sid, e_sex, e_smem, e_bub, e_fid, e_fex, e_to} = '0;
        e_red = 0;
        hz = d.id_valid && d.ex_is_load && d.ex_writeenable && (d.ex_rd != 0)
             && ((d.id_uses_rs && d.id_rs == d.ex_rd) || (d.id_uses_rt && d.id_rt == d.ex_rd));
`ifdef PIPELINE_CTRL_PERF_EN
        check_eq("load_stall_cnt", load_stall_cnt, m_lu);
        check_eq("mem_wait_cnt", mem_wait_cnt, m_mw);
`else
        check_eq("load_stall_cnt", load_stall_cnt, 32'd0);
        check_eq("mem_wait_cnt", mem_wait_cnt, 32'd0);
`endif
        if (d.reset) begin
            m_waiting = 0; m_waited = 0; m_drain_left = 0;
            m_blank = 1; m_lu = 0; m_mw = 0;
        end else if (m_blank) begin
            m_blank = 0;
        end else if (m_waiting) begin
            m_mw++;
            if (d.mem_ready) begin
                m_waiting = 0;
            end else if (m_waited + 1 == MEM_TIMEOUT) begin
                e_to = 1; e_red = 2; e_fid = 1; e_fex = 1;
                m_waiting = 0;
                m_drain_left = DRAIN_CYCLES;
            end else begin
                {e_sif, e_sid, e_sex, e_smem} = 4'b1111;
                m_waited++;
            end
        end else if (m_drain_left > 0) begin
            if (d.ex_exception) begin
                e_red = 2; e_fid = 1; e_fex = 1;
                m_drain_left = DRAIN_CYCLES;
            end else begin
                e_sif = 1; e_fid = 1;
                m_drain_left--;
            end
        end else if (d.mem_req && !d.mem_ready) begin
            {e_sif, e_sid, e_sex, e_smem} = 4'b1111;
            m_waiting = 1;
            m_waited = 1;
        end else if (d.ex_exception) begin
            e_red = 2; e_fid = 1; e_fex = 1;
            m_drain_left = DRAIN_CYCLES;
        end else if (d.ex_eret) begin
            e_red = 3; e_fid = 1; e_fex = 1;
        end else if (d.ex_branch_taken) begin
            e_red = 1; e_fid = 1;
        end else if (hz) begin
            e_sif = 1; e_sid = 1; e_bub = 1;
            m_lu++;
        end
        check_eq("stall_if", 32'(stall_if), 32'(e_sif));
        check_eq("stall_id", 32'(stall_id), 32'(e_sid));
        check_eq("stall_ex", 32'(stall_ex), 32'(e_sex));
        check_eq("stall_mem", 32'(stall_mem), 32'(e_smem));
        check_eq("bubble_ex", 32'(bubble_ex), 32'(e_bub));
        check_eq("flush_id", 32'(flush_id), 32'(e_fid));
        check_eq("flush_ex", 32'(flush_ex), 32'(e_fex));
        check_eq("redirect_sel", 32'(redirect_sel), 32'(e_red));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(e_to));
        cyc++;
    endtask

    task automatic rand_stim(input int mode);
        s.reset           = ($urandom_range(0, 199) == 0);
        s.id_valid        = ($urandom_range(0, 7) != 0);
        s.id_rs           = 5'($urandom_range(0, 3));
        s.id_rt           = 5'($urandom_range(0, 3));
        s.id_uses_rs      = 1'($urandom_range(0, 1));
        s.id_uses_rt      = 1'($urandom_range(0, 1));
        s.ex_rd           = 5'($urandom_range(0, 3));
        s.ex_writeenable  = ($urandom_range(0, 3) != 0);
        s.ex_is_load      = 1'($urandom_range(0, 1));
        s.ex_branch_taken = ($urandom_range(0, 5) == 0);
        s.ex_exception    = ($urandom_range(0, 15) == 0);
        s.ex_eret         = ($urandom_range(0, 15) == 0);
        s.mem_req         = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
        case (mode)
            0:       s.mem_ready = 1'($urandom_range(0, 1));
            1:       s.mem_ready = 1'b0;
            2:       s.mem_ready = ($urandom_range(0, 3) != 0);
            default: s.mem_ready = ($urandom_range(0, 7) == 0);
        endcase
    endtask

    initial begin
        int to_at;
        int drain_stalls;
        d = '0;
        d.reset = 1'b1;
        s = d;

        // Reset: outputs held at zero while reset is high
        repeat (3) begin
            run_cycle();
            check_eq("rst_outs", outs_vec(), 32'd0);
        end
        s.reset = 1'b0;
        run_cycle();
        check_eq("post_rst_outs", outs_vec(), 32'd0);
        run_cycle();

        // Load-use on $5 via rs, then rd=0 and uses_rs=0 variants
        s.ex_rd = 5'd5; s.ex_is_load = 1; s.ex_writeenable = 1;
        s.id_valid = 1; s.id_rs = 5'd5; s.id_uses_rs = 1;
        run_cycle();
        check_eq("lu_bubble", 32'(bubble_ex), 32'd1);
        s.ex_rd = 5'd0; s.id_rs = 5'd0;
        run_cycle();
        s.ex_rd = 5'd5; s.id_rs = 5'd5; s.id_uses_rs = 0;
        run_cycle();
        s = '0;
        run_cycle();

        // Taken branch
        s.ex_branch_taken = 1;
        run_cycle();
        s = '0;

        // Memory wait released by mem_ready after 3 stalled cycles
        s.mem_req = 1;
        repeat (3) run_cycle();
        s.mem_ready = 1;
        run_cycle();
        check_eq("mw_release", 32'(stall_mem), 32'd0);
        s = '0;
        run_cycle();

        // Timeout: pulse on cycle MEM_TIMEOUT, then DRAIN_CYCLES of stall_if
        to_at = 0;
        drain_stalls = 0;
        s.mem_req = 1;
        for (int i = 1; i <= 20; i++) begin
            run_cycle();
            if (mem_timeout && to_at == 0) to_at = i;
            if (i > MEM_TIMEOUT && i <= MEM_TIMEOUT + DRAIN_CYCLES && stall_if) drain_stalls++;
        end
        check_eq("timeout_cycle", 32'(to_at), 32'(MEM_TIMEOUT));
        check_eq("drain_len", 32'(drain_stalls), 32'(DRAIN_CYCLES));
        s = '0;
        s.mem_ready = 1;
        run_cycle();
        s = '0;
        repeat (4) run_cycle();

        // Priority: exception beats branch and load-use
        s.ex_exception = 1; s.ex_branch_taken = 1;
        s.ex_rd = 5'd7; s.ex_is_load = 1; s.ex_writeenable = 1;
        s.id_valid = 1; s.id_rt = 5'd7; s.id_uses_rt = 1;
        run_cycle();
        check_eq("prio_redirect", 32'(redirect_sel), 32'd2);
        check_eq("prio_no_bubble", 32'(bubble_ex), 32'd0);
        s = '0;
        repeat (3) run_cycle();

        // Reset in the middle of a memory wait
        s.mem_req = 1;
        repeat (4) run_cycle();
        s.reset = 1;
        run_cycle();
        s.reset = 0;
        run_cycle();
        check_eq("rst_midwait_outs", outs_vec(), 32'd0);
        check_eq("rst_midwait_cnt", mem_wait_cnt, 32'd0);
        s = '0;
        run_cycle();

        // Randomized segments
        for (int seg = 0; seg < 60; seg++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 3);
            len  = $urandom_range(10, 40);
            for (int k = 0; k < len; k++) begin
                rand_stim(mode);
                run_cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush/redirect scheduler for the 5-stage 64-bit MIPS pipeline (IF, ID, EX, MEM, WB).
- Consumes decoded control fields for the ID and EX instructions and the data-memory handshake.
- Produces per-stage stall and flush enables and the next-PC source select.
- Owns the multi-cycle sequencing: memory wait with timeout and exception drain.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before a bus-timeout exception; legal range 2..255.
- DRAIN_CYCLES, 2, cycles IF stays stalled after an exception redirect; legal range 1..7.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt (B_is_reg)
- ex_rd  in  5  EX destination register, after rd_src muxing
- ex_writeenable  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load (mem_load_type != 0)
- ex_branch_taken  in  1  EX branch/jump resolved taken
- ex_exception  in  1  EX carries except/syscall/break_
- ex_eret  in  1  EX instruction is ERET
- mem_req  in  1  MEM stage issues a data access
- mem_ready  in  1  data memory completes the access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold the IF/ID register
- stall_ex  out  1  hold the ID/EX register
- stall_mem  out  1  hold the EX/MEM register
- bubble_ex  out  1  load a NOP into the ID/EX register
- flush_id  out  1  clear the IF/ID register
- flush_ex  out  1  clear the ID/EX register
- redirect_sel  out  2  next-PC source: 0 = sequential, 1 = branch target, 2 = exception vector, 3 = EPC
- mem_timeout  out  1  one-cycle pulse when MEM_WAIT expires
- load_stall_cnt  out  32  performance counter (optional feature)
- mem_wait_cnt  out  32  performance counter (optional feature)

Behaviour:
- Reset: state = RUN, wait counter = 0, drain counter = 0. All outputs are 0 during reset and in the first cycle after it.
- All outputs are combinational from the current state plus the inputs; state is registered.

State RUN. Conditions are evaluated in this priority order; the first match wins:
1. mem_req && !mem_ready
   - Assert stall_if, stall_id, stall_ex, stall_mem.
   - Next state MEM_WAIT, wait counter = 1.
2. ex_exception
   - Assert redirect_sel = 2, flush_id, flush_ex.
   - Next state DRAIN, drain counter = DRAIN_CYCLES.
3. ex_eret
   - Assert redirect_sel = 3, flush_id, flush_ex.
   - Stay in RUN.
4. ex_branch_taken
   - Assert redirect_sel = 1, flush_id.
   - Stay in RUN.
5. Load-use hazard
   - Condition: ex_is_load && ex_writeenable && ex_rd != 0 && id_valid && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd)).
   - Assert stall_if, stall_id, bubble_ex for exactly that cycle. No state change; the condition self-clears once the load advances.

State MEM_WAIT:
- Hold all four stalls.
- mem_ready = 1: return to RUN next cycle and clear the counter. The stalls are deasserted in the same cycle mem_ready is seen.
- mem_ready = 0 and counter == MEM_TIMEOUT-1:
  - Pulse mem_timeout.
  - Assert redirect_sel = 2, flush_id, flush_ex.
  - Next state DRAIN.
- Otherwise increment the counter. The counter saturates and never wraps.
- ex_branch_taken and ex_exception are ignored while in MEM_WAIT; they are re-evaluated after the stall releases.

State DRAIN:
- Assert stall_if and flush_id; decrement the drain counter.
- Return to RUN when the counter reaches 0. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- ex_exception arriving during DRAIN reloads the counter and redirects again with redirect_sel = 2.

General rules:
- flush has priority over stall on the same register; bubble_ex is never asserted together with flush_ex.
- A reset asserted mid-MEM_WAIT or mid-DRAIN returns to RUN on the next edge and discards all counters.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Defined: two 32-bit wrapping counters, cleared by reset.
  - load_stall_cnt increments on every load-use bubble cycle.
  - mem_wait_cnt increments on every cycle spent in MEM_WAIT.
- Undefined: both counter registers are omitted and the two ports are tied to 0.

Decomposition:
- Into package structures:
  - pipe_ctrl_state_t enum {RUN, MEM_WAIT, DRAIN}
  - redirect_src_t enum {REDIR_SEQ, REDIR_BRANCH, REDIR_EXC, REDIR_EPC}
  - EXC_DRAIN_DEFAULT constant
- One sub-module: load_use_detect, the purely combinational hazard compare, reused by the forwarding unit.

Test Plan:
- Load-use: EX = LW to $5 (ex_rd=5, load, we=1); ID reads rs=5 → exactly 1 cycle of stall_if/stall_id/bubble_ex; none if ex_rd=0 or id_uses_rs=0.
- Branch: ex_branch_taken=1 in RUN → redirect_sel=1 and flush_id=1 for one cycle, no stalls.
- Memory wait: mem_req=1, mem_ready low for 3 cycles, then high → all stalls high for 3 cycles, released in the mem_ready cycle, back to RUN.
- Timeout: mem_ready held low, MEM_TIMEOUT=16 → mem_timeout pulses on cycle 16, redirect_sel=2, then 2 DRAIN cycles of stall_if.
- Priority: ex_exception and ex_branch_taken in the same cycle → redirect_sel=2 with flush_ex=1; a load-use hazard in the same cycle produces no bubble_ex.
- Reset mid-MEM_WAIT (cycle 5) → all outputs 0 next cycle, state RUN; with PIPELINE_CTRL_PERF_EN, mem_wait_cnt=0.
